// File: rtl/term_writer.sv
// term_writer: turns a byte stream into VRAM writes for a character terminal.
// It handles printable characters, CR, LF, BS, TAB and FF (clear screen).
// When the cursor passes the bottom row it either scrolls the screen in
// hardware by moving the top-of-screen row pointer, or wraps to row 0.
//
// Ports
//   clk         sole clock, rising edge
//   reset_n     asynchronous active-low reset
//   rx_data     incoming character byte
//   rx_valid    rx_data valid
//   rx_ready    byte accepted this cycle (only in IDLE)
//   vram_we     VRAM write strobe, one cycle per write
//   vram_addr   physical VRAM address
//   vram_data   byte to write
//   cursor_col  logical cursor column
//   cursor_row  logical cursor row (0 = top of visible screen)
//   scroll_row  physical row shown at the top of the screen
//   busy        high whenever the FSM is not in IDLE
module term_writer #(
  parameter int COLS      = 80,
  parameter int ROWS      = 30,
  parameter int TAB_W     = 8,
  parameter int SCROLL_EN = 1,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_data,
  output logic [7:0]        cursor_col,
  output logic [7:0]        cursor_row,
  output logic [7:0]        scroll_row,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [7:0]        COL_MAX   = 8'(COLS - 1);
  localparam logic [7:0]        ROW_MAX   = 8'(ROWS - 1);
  localparam logic [8:0]        TAB_MASK  = ~(9'(TAB_W - 1));
  localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(ROWS * COLS - 1);

  state_t            state;
  logic [7:0]        cmd;
  logic [ADDR_W-1:0] clr_base;
  logic [ADDR_W-1:0] clr_last;
  logic [ADDR_W-1:0] clr_cnt;
  // A printable at the end of the bottom row shows its own write first,
  // then the line clear follows; this flag marks that pending clear.
  logic              clr_pend;

  // Newline outcome, evaluated from the current cursor.
  logic [7:0]        nl_row;
  logic [7:0]        nl_scroll;
  logic              nl_clear;

  // Result of executing the latched byte.
  logic [7:0]        ex_col;
  logic [7:0]        ex_row;
  logic [7:0]        ex_scroll;
  logic              ex_we;
  logic [7:0]        ex_data;
  logic [ADDR_W-1:0] ex_addr;
  logic              ex_clear;
  logic [ADDR_W-1:0] ex_base;
  logic [ADDR_W-1:0] ex_last;
  logic [8:0]        tab_pos;

  // Logical (row, col) to physical address; row+scroll is below 2*ROWS so a
  // single conditional subtract implements the modulo.
  function automatic logic [ADDR_W-1:0] phys_addr(input logic [7:0] r,
                                                  input logic [7:0] s,
                                                  input logic [7:0] c);
    logic [8:0] sum;
    logic [8:0] prow;
    sum  = {1'b0, r} + {1'b0, s};
    prow = (sum >= 9'(ROWS)) ? (sum - 9'(ROWS)) : sum;
    return (ADDR_W'(prow) * ADDR_W'(COLS)) + ADDR_W'(c);
  endfunction

  // Newline: step down, scroll with a bottom-line clear, or wrap to the top.
  always_comb begin
    nl_row    = cursor_row;
    nl_scroll = scroll_row;
    nl_clear  = 1'b0;
    if (cursor_row != ROW_MAX) begin
      nl_row = cursor_row + 8'd1;
    end else if (SCROLL_EN != 0) begin
      nl_scroll = (scroll_row == ROW_MAX) ? 8'd0 : (scroll_row + 8'd1);
      nl_clear  = 1'b1;
    end else begin
      nl_row = 8'd0;
    end
  end

  // Decode the latched byte into the next cursor, write and clear request.
  always_comb begin
    ex_col    = cursor_col;
    ex_row    = cursor_row;
    ex_scroll = scroll_row;
    ex_we     = 1'b0;
    ex_data   = 8'h20;
    ex_addr   = phys_addr(cursor_row, scroll_row, cursor_col);
    ex_clear  = 1'b0;
    // The new bottom line lives in the physical row that was on top before.
    ex_base   = ADDR_W'(scroll_row) * ADDR_W'(COLS);
    ex_last   = LINE_LAST;
    tab_pos   = ({1'b0, cursor_col} & TAB_MASK) + 9'(TAB_W);
    case (cmd)
      8'h0D: begin
        ex_col = 8'd0;
      end
      8'h0A: begin
        ex_row    = nl_row;
        ex_scroll = nl_scroll;
        ex_clear  = nl_clear;
      end
      8'h08: begin
        if (cursor_col != 8'd0) begin
          ex_col  = cursor_col - 8'd1;
          ex_we   = 1'b1;
          ex_addr = phys_addr(cursor_row, scroll_row, cursor_col - 8'd1);
        end else begin
          ex_we = 1'b0;
        end
      end
      8'h09: begin
        if (tab_pos > {1'b0, COL_MAX}) begin
          ex_col = COL_MAX;
        end else begin
          ex_col = tab_pos[7:0];
        end
      end
      8'h0C: begin
        ex_col    = 8'd0;
        ex_row    = 8'd0;
        ex_scroll = 8'd0;
        ex_clear  = 1'b1;
        ex_base   = '0;
        ex_last   = CELL_LAST;
      end
      default: begin
        if ((cmd >= 8'h20) && (cmd <= 8'h7E)) begin
          ex_we   = 1'b1;
          ex_data = cmd;
          if (cursor_col == COL_MAX) begin
            ex_col    = 8'd0;
            ex_row    = nl_row;
            ex_scroll = nl_scroll;
            ex_clear  = nl_clear;
          end else begin
            ex_col = cursor_col + 8'd1;
          end
        end else begin
          ex_we = 1'b0;
        end
      end
    endcase
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cmd        <= 8'h00;
      clr_base   <= '0;
      clr_last   <= '0;
      clr_cnt    <= '0;
      clr_pend   <= 1'b0;
      cursor_col <= 8'd0;
      cursor_row <= 8'd0;
      scroll_row <= 8'd0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_data  <= 8'h00;
      rx_ready   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vram_we <= 1'b0;
          if (rx_valid && rx_ready) begin
            cmd      <= rx_data;
            state    <= EXEC;
            rx_ready <= 1'b0;
            busy     <= 1'b1;
          end else begin
            rx_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        EXEC: begin
          cursor_col <= ex_col;
          cursor_row <= ex_row;
          scroll_row <= ex_scroll;
          clr_base   <= ex_base;
          clr_last   <= ex_last;
          clr_cnt    <= '0;
          if (ex_clear) begin
            state   <= CLEAR;
            vram_we <= 1'b1;
            if (ex_we) begin
              clr_pend  <= 1'b1;
              vram_addr <= ex_addr;
              vram_data <= ex_data;
            end else begin
              clr_pend  <= 1'b0;
              vram_addr <= ex_base;
              vram_data <= 8'h20;
            end
          end else begin
            state    <= IDLE;
            rx_ready <= 1'b1;
            busy     <= 1'b0;
            clr_pend <= 1'b0;
            vram_we  <= ex_we;
            if (ex_we) begin
              vram_addr <= ex_addr;
              vram_data <= ex_data;
            end else begin
              vram_addr <= vram_addr;
              vram_data <= vram_data;
            end
          end
        end
        CLEAR: begin
          vram_data <= 8'h20;
          if (clr_pend) begin
            clr_pend  <= 1'b0;
            clr_cnt   <= '0;
            vram_we   <= 1'b1;
            vram_addr <= clr_base;
          end else if (clr_cnt == clr_last) begin
            state    <= IDLE;
            vram_we  <= 1'b0;
            rx_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            clr_cnt   <= clr_cnt + ADDR_W'(1);
            vram_we   <= 1'b1;
            vram_addr <= clr_base + clr_cnt + ADDR_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          vram_we  <= 1'b0;
          rx_ready <= 1'b0;
          busy     <= 1'b0;
          clr_pend <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_term_writer.sv
// Bench for term_writer: two instances (SCROLL_EN=0 and SCROLL_EN=1) receive
// the same directed byte stream. Expected VRAM writes are queued per instance
// when a byte is issued; monitors pop and compare every observed write.
module tb_term_writer;

  logic        clk;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid0, rx_valid1;
  logic        rx_ready0, rx_ready1;
  logic        vram_we0, vram_we1;
  logic [15:0] vram_addr0, vram_addr1;
  logic [7:0]  vram_data0, vram_data1;
  logic [7:0]  col0, col1, row0, row1, scr0, scr1;
  logic        busy0, busy1;

  int n_checks = 0;
  int n_fail   = 0;
  int q0[$];
  int q1[$];

  term_writer #(.COLS(80), .ROWS(30), .TAB_W(8), .SCROLL_EN(0), .ADDR_W(16)) u0 (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid0),
    .rx_ready(rx_ready0), .vram_we(vram_we0), .vram_addr(vram_addr0),
    .vram_data(vram_data0), .cursor_col(col0), .cursor_row(row0),
    .scroll_row(scr0), .busy(busy0));

  term_writer #(.COLS(80), .ROWS(30), .TAB_W(8), .SCROLL_EN(1), .ADDR_W(16)) u1 (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid1),
    .rx_ready(rx_ready1), .vram_we(vram_we1), .vram_addr(vram_addr1),
    .vram_data(vram_data1), .cursor_col(col1), .cursor_row(row1),
    .scroll_row(scr1), .busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard monitor, instance 0.
  always @(negedge clk) begin
    if (reset_n && vram_we0) begin
      n_checks++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL wr0_unexpected: addr %0d data 0x%0h, expected no write", vram_addr0, vram_data0);
      end else begin
        int e;
        e = q0.pop_front();
        if ((int'(vram_addr0) * 256 + int'(vram_data0)) != e) begin
          n_fail++;
          $display("FAIL wr0: addr %0d data 0x%0h, expected addr %0d data 0x%0h",
                   vram_addr0, vram_data0, e / 256, e % 256);
        end
      end
    end
  end

  // Scoreboard monitor, instance 1.
  always @(negedge clk) begin
    if (reset_n && vram_we1) begin
      n_checks++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL wr1_unexpected: addr %0d data 0x%0h, expected no write", vram_addr1, vram_data1);
      end else begin
        int e;
        e = q1.pop_front();
        if ((int'(vram_addr1) * 256 + int'(vram_data1)) != e) begin
          n_fail++;
          $display("FAIL wr1: addr %0d data 0x%0h, expected addr %0d data 0x%0h",
                   vram_addr1, vram_data1, e / 256, e % 256);
        end
      end
    end
  end

  function automatic void push_both(input int a, input int d);
    q0.push_back(a * 256 + d);
    q1.push_back(a * 256 + d);
  endfunction

  // Hand a byte to both instances, then wait until both are ready again,
  // counting the cycles each held rx_ready low. Returns on a falling edge.
  task automatic send(input logic [7:0] b, output int low0, output int low1);
    bit acc0, acc1;
    int guard;
    acc0 = 1'b0; acc1 = 1'b0; guard = 0; low0 = 0; low1 = 0;
    rx_data = b;
    while (!(acc0 && acc1) && guard < 200) begin
      @(negedge clk);
      rx_valid0 = !acc0 && rx_ready0;
      rx_valid1 = !acc1 && rx_ready1;
      @(posedge clk);
      if (rx_valid0) acc0 = 1'b1;
      if (rx_valid1) acc1 = 1'b1;
      #1;
      rx_valid0 = 1'b0;
      rx_valid1 = 1'b0;
      guard++;
    end
    if (!(acc0 && acc1)) chk("accept_timeout", 0, 1);
    guard = 0;
    do begin
      @(negedge clk);
      if (!rx_ready0) low0++;
      if (!rx_ready1) low1++;
      guard++;
    end while ((!rx_ready0 || !rx_ready1) && guard < 5000);
    if (!rx_ready0 || !rx_ready1) chk("ready_timeout", 0, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we0"}, int'(vram_we0), 0);     chk({tag, "_we1"}, int'(vram_we1), 0);
    chk({tag, "_addr0"}, int'(vram_addr0), 0); chk({tag, "_addr1"}, int'(vram_addr1), 0);
    chk({tag, "_data0"}, int'(vram_data0), 0); chk({tag, "_data1"}, int'(vram_data1), 0);
    chk({tag, "_col0"}, int'(col0), 0);        chk({tag, "_col1"}, int'(col1), 0);
    chk({tag, "_row0"}, int'(row0), 0);        chk({tag, "_row1"}, int'(row1), 0);
    chk({tag, "_scr0"}, int'(scr0), 0);        chk({tag, "_scr1"}, int'(scr1), 0);
    chk({tag, "_busy0"}, int'(busy0), 0);      chk({tag, "_busy1"}, int'(busy1), 0);
    chk({tag, "_rdy0"}, int'(rx_ready0), 0);   chk({tag, "_rdy1"}, int'(rx_ready1), 0);
  endtask

  initial begin
    int l0, l1, guard;
    reset_n = 1'b0; rx_data = 8'h00; rx_valid0 = 1'b0; rx_valid1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("rst");
    @(negedge clk) reset_n = 1'b1;
    #1 chk("rdy_before_edge", int'(rx_ready0), 0);
    @(posedge clk) #1 chk("rdy_after_edge", int'(rx_ready1), 1);

    // 'A' at (0,0): single write at addr 0, cursor col 1.
    push_both(0, 8'h41);
    send(8'h41, l0, l1);
    chk("A_col", int'(col0), 1); chk("A_row", int'(row0), 0);
    chk("A_col1", int'(col1), 1);
    @(posedge clk) #1 chk("A_we_one_cycle", int'(vram_we0), 0);

    // CR, then a full row of printables: last at addr 79, cursor (1,0).
    send(8'h0D, l0, l1);
    chk("CR_col", int'(col0), 0);
    for (int i = 0; i < 80; i++) begin
      push_both(i, 32 + i);
      send(8'(32 + i), l0, l1);
    end
    chk("row_full_row", int'(row1), 1); chk("row_full_col", int'(col1), 0);

    // BS at col 0 does nothing; BS at col 3 blanks col 2.
    send(8'h08, l0, l1);
    chk("BS0_col", int'(col0), 0); chk("BS0_row", int'(row0), 1);
    push_both(80, 8'h78); send(8'h78, l0, l1);
    push_both(81, 8'h79); send(8'h79, l0, l1);
    push_both(82, 8'h7A); send(8'h7A, l0, l1);
    chk("xyz_col", int'(col0), 3);
    push_both(82, 8'h20); send(8'h08, l0, l1);
    chk("BS3_col", int'(col0), 2);

    // TAB stops and clamping at the right edge.
    send(8'h09, l0, l1);
    chk("TAB2_col", int'(col0), 8);
    send(8'h0D, l0, l1);
    for (int i = 0; i < 9; i++) send(8'h09, l0, l1);
    chk("TAB9_col", int'(col1), 72);
    for (int i = 0; i < 5; i++) begin
      push_both(152 + i, 8'h6D);
      send(8'h6D, l0, l1);
    end
    chk("col77", int'(col0), 77);
    send(8'h09, l0, l1);
    chk("TAB77_col", int'(col0), 79);
    send(8'h09, l0, l1);
    chk("TAB79_col", int'(col1), 79);

    // Printable at last column wraps to next row.
    push_both(159, 8'h77); send(8'h77, l0, l1);
    chk("wrap_row", int'(row0), 2); chk("wrap_col", int'(col0), 0);

    // Unhandled bytes are ignored.
    send(8'h01, l0, l1);
    send(8'h7F, l0, l1);
    chk("ign_row", int'(row1), 2); chk("ign_col", int'(col1), 0);

    // Move to (29,5).
    for (int i = 0; i < 27; i++) send(8'h0A, l0, l1);
    chk("LF27_row", int'(row0), 29); chk("LF27_col", int'(col0), 0);
    for (int i = 0; i < 5; i++) begin
      push_both(2320 + i, 8'h61 + i);
      send(8'(8'h61 + i), l0, l1);
    end
    chk("pre_scroll_col", int'(col1), 5);

    // LF at bottom row: scroll + 80-cell clear vs. wrap to top.
    for (int i = 0; i < 80; i++) q1.push_back(i * 256 + 8'h20);
    send(8'h0A, l0, l1);
    chk("scr1_scroll", int'(scr1), 1);
    chk("scr1_row", int'(row1), 29); chk("scr1_col", int'(col1), 5);
    chk("scr1_low_cycles", l1, 81);
    chk("scr0_scroll", int'(scr0), 0);
    chk("scr0_row", int'(row0), 0); chk("scr0_col", int'(col0), 5);
    chk("scr0_low_cycles", l0, 1);

    // Next printable: (29+1) mod 30 = physical row 0 for the scrolled screen.
    push_both(5, 8'h71); send(8'h71, l0, l1);
    chk("post_scroll_col", int'(col1), 6);
    @(posedge clk) #1;
    chk("q0_drained", q0.size(), 0); chk("q1_drained", q1.size(), 0);

    // FF: full clear, interrupted by reset at cell 100.
    for (int i = 0; i < 2400; i++) begin
      q0.push_back(i * 256 + 8'h20);
      q1.push_back(i * 256 + 8'h20);
    end
    rx_data = 8'h0C;
    @(negedge clk) begin rx_valid0 = 1'b1; rx_valid1 = 1'b1; end
    @(posedge clk) #1 begin rx_valid0 = 1'b0; rx_valid1 = 1'b0; end
    guard = 0;
    while (!(vram_we1 && vram_addr1 == 16'd100) && guard < 300) begin
      @(posedge clk) #1;
      guard++;
    end
    chk("FF_reach_cell100", int'(vram_addr1), 100);
    chk("FF_scroll", int'(scr1), 0); chk("FF_row", int'(row1), 0);
    chk("FF_col", int'(col1), 0); chk("FF_busy", int'(busy1), 1);
    chk("FF_rdy", int'(rx_ready0), 0);
    reset_n = 1'b0;
    q0.delete(); q1.delete();
    #1 chk_reset_outputs("midclr");
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1 chk("rel_rdy_before_edge", int'(rx_ready1), 0);
    @(posedge clk) #1;
    chk("rel_rdy0", int'(rx_ready0), 1); chk("rel_rdy1", int'(rx_ready1), 1);

    // Recovery after abandoned clear.
    push_both(0, 8'h41); send(8'h41, l0, l1);
    chk("rec_col", int'(col0), 1);
    @(posedge clk) #1;
    chk("rec_q0", q0.size(), 0); chk("rec_q1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/term_writer.md
TERM_WRITER -- requirements
Module: term_writer

Interface
REQ-001 SHALL have parameter COLS, default 80, characters per text row (2..255).
REQ-002 SHALL have parameter ROWS, default 30, text rows per screen (2..255).
REQ-003 SHALL have parameter TAB_W, default 8, tab stop spacing in columns (power of two).
REQ-004 SHALL have parameter SCROLL_EN, default 1: 1 = hardware scroll at bottom row, 0 = cursor wraps to row 0.
REQ-005 SHALL have parameter ADDR_W, default 16, VRAM address width (must hold ROWS*COLS-1).
REQ-006 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port rx_data  input  8  incoming character byte.
REQ-009 SHALL have port rx_valid  input  1  rx_data valid.
REQ-010 SHALL have port rx_ready  output  1  block accepts a byte this cycle.
REQ-011 SHALL have port vram_we  output  1  VRAM write strobe, one cycle per write.
REQ-012 SHALL have port vram_addr  output  ADDR_W  physical VRAM address.
REQ-013 SHALL have port vram_data  output  8  byte to write.
REQ-014 SHALL have port cursor_col  output  8  logical cursor column.
REQ-015 SHALL have port cursor_row  output  8  logical cursor row (0 = top of visible screen).
REQ-016 SHALL have port scroll_row  output  8  physical row shown at the top of the screen, for the video scanner.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, EXEC and CLEAR; rx_ready = 1 only in IDLE.
REQ-019 SHALL latch rx_data on the edge where rx_valid & rx_ready is high and move IDLE->EXEC; EXEC lasts exactly one cycle.
REQ-020 SHALL register all outputs; a write from EXEC appears as vram_we = 1 for exactly one cycle, starting at the edge that leaves EXEC, with the updated cursor visible in the same cycle.
REQ-021 SHALL compute the physical address as ((cursor_row + scroll_row) mod ROWS)*COLS + cursor_col, with no overflow into ADDR_W.
REQ-022 SHALL treat 0x20..0x7E as printable: write the byte at the cursor, then col+1; at col COLS-1 set col = 0 and perform a newline (REQ-027).
REQ-023 SHALL treat 0x0D (CR) as col = 0 with no write.
REQ-024 SHALL treat 0x0A (LF) as a newline (REQ-027) with col unchanged and no write.
REQ-025 SHALL treat 0x08 (BS) as: if col > 0, col-1 and write 0x20 at the new position; if col = 0, no action and no write.
REQ-026 SHALL treat 0x09 (TAB) as col = next multiple of TAB_W, clamped to COLS-1, with no write.
REQ-026a SHALL treat 0x0C (FF) as: cursor = (0,0), scroll_row = 0, then CLEAR over all ROWS*COLS cells.
REQ-026b SHALL ignore all other bytes: no write and no cursor change; the FSM returns to IDLE.
REQ-027 SHALL perform a newline as follows: if row < ROWS-1, row+1; else if SCROLL_EN, scroll_row = (scroll_row+1) mod ROWS, row stays ROWS-1, then CLEAR the new bottom line (COLS cells); else row = 0 with no clear.
REQ-028 SHALL, in CLEAR, write 0x20 on consecutive cycles with vram_we = 1 every cycle, addresses ascending; when the last cell is written, return to IDLE.
REQ-029 SHALL hold rx_ready = 0 throughout EXEC and CLEAR; rx_data and rx_valid are ignored there, and the upstream holds its byte.
REQ-030 SHALL hold vram_we = 0 in IDLE.
REQ-031 SHALL keep cursor_col < COLS, cursor_row < ROWS and scroll_row < ROWS at all times.

Reset
REQ-032 SHALL, while reset_n = 0, force state IDLE, cursor_col = cursor_row = scroll_row = 0, vram_we = 0, vram_addr = 0, vram_data = 0, busy = 0 and rx_ready = 0.
REQ-033 SHALL set rx_ready = 1 from the first clk edge after reset_n deasserts.
REQ-034 SHALL, on reset asserted mid-EXEC or mid-CLEAR, abandon the operation immediately; the partially cleared VRAM is not restored.

Verification
REQ-035 Bench SHALL cover: defaults, "A" (0x41) after reset -> vram_we one cycle, addr 0, data 0x41, cursor_col 1.
REQ-036 Bench SHALL cover: 80 printables on row 0 -> the last is written at addr 79, cursor becomes (row 1, col 0).
REQ-037 Bench SHALL cover: cursor (29,5), LF with SCROLL_EN=1 -> scroll_row 1, 80 consecutive writes of 0x20 at addr 0..79, cursor (29,5), rx_ready low for 81 cycles.
REQ-038 Bench SHALL cover: the same LF with SCROLL_EN=0 -> cursor (0,5), no writes, scroll_row 0.
REQ-039 Bench SHALL cover: BS at col 0 -> no write; BS at col 3 -> write 0x20 at col 2, cursor_col 2; TAB at col 77 -> col 79.
REQ-040 Bench SHALL cover: FF, then reset_n pulsed low at cell 100 of the clear -> all outputs at reset values, rx_ready 1 one edge after release.
